// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the FIFO, its interface and the register block.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_LEVEL_W    = 8;
  localparam int UART_FIFO_DEPTH = 16;

  // Values for the FIFO THRESH_MODE parameter.
  localparam int THRESH_GE = 0;  // RX: flag when level >= threshold
  localparam int THRESH_LE = 1;  // TX: flag when level <= threshold

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;
  typedef logic [UART_LEVEL_W-1:0]   uart_level_t;

endpackage

// File: rtl/uart_fifo_if.sv
// Handshake and status bundle between a UART FIFO and its producer/consumer logic.
interface uart_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
) ();

  logic                 flush;
  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 rd_en;
  logic [DATA_BITS-1:0] rd_data;
  logic                 full;
  logic                 empty;
  uart_level_t          level;
  uart_level_t          threshold;
  logic                 threshold_reached;
  logic                 overrun;
  logic                 underrun;

  // Side that owns the FIFO storage.
  modport slave (
    input  flush, wr_en, wr_data, rd_en, threshold,
    output rd_data, full, empty, level, threshold_reached, overrun, underrun
  );

  // Side that pushes, pops and watches status.
  modport master (
    output flush, wr_en, wr_data, rd_en, threshold,
    input  rd_data, full, empty, level, threshold_reached, overrun, underrun
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_BITS register array: synchronous write, asynchronous read, no reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH     = UART_FIFO_DEPTH,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  // Store the pushed word; contents survive reset and flush by design.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo.sv
// First-word-fall-through byte FIFO with level/threshold status, sticky overrun
// and a one-cycle underrun pulse. Used for both the TX and RX paths.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int DEPTH       = UART_FIFO_DEPTH,
  parameter int THRESH_MODE = THRESH_GE
) (
  input logic        clk,
  input logic        rst,
  uart_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overrun_q;
  logic             underrun_q;
  logic             full_w;
  logic             empty_w;
  logic             push_ok;
  logic             pop_ok;
  logic             mem_we;

  // Compare direction is fixed per instance: RX wants "at least", TX wants "at most".
  function automatic logic thresh_hit(input uart_level_t lvl, input uart_level_t thr);
    if (THRESH_MODE == THRESH_LE) begin
      return lvl <= thr;
    end
    return lvl >= thr;
  endfunction

  assign full_w  = (count == CNT_W'(DEPTH));
  assign empty_w = (count == '0);

  // A push into a full FIFO is only legal when a pop frees the slot in the same cycle;
  // a pop from an empty FIFO is refused even if a push arrives alongside it.
  assign pop_ok  = bus.rd_en & ~empty_w;
  assign push_ok = bus.wr_en & (~full_w | bus.rd_en);
  assign mem_we  = push_ok & ~bus.flush & ~rst;

  uart_fifo_mem #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (bus.rd_data)
  );

  // Pointer, occupancy and error-flag state; flush clears exactly what reset clears.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (bus.wr_en && full_w && !bus.rd_en) begin
        overrun_q <= 1'b1;
      end
      underrun_q <= bus.rd_en & empty_w;
    end
  end

  assign bus.full              = full_w;
  assign bus.empty             = empty_w;
  assign bus.level             = UART_LEVEL_W'(count);
  assign bus.threshold_reached = thresh_hit(UART_LEVEL_W'(count), bus.threshold);
  assign bus.overrun           = overrun_q;
  assign bus.underrun          = underrun_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: one RX-style (>=) and one TX-style (<=) instance.
module tb_uart_fifo;
  import uart_pkg::*;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  uart_fifo_if #(.DATA_BITS(8)) bus_a ();
  uart_fifo_if #(.DATA_BITS(8)) bus_b ();

  uart_fifo #(.DATA_BITS(8), .DEPTH(16), .THRESH_MODE(THRESH_GE)) u_ge (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  uart_fifo #(.DATA_BITS(8), .DEPTH(16), .THRESH_MODE(THRESH_LE)) u_le (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock on instance A; inputs are held across the edge, outputs settle by #1.
  task automatic cyc(input bit we, input bit re, input logic [7:0] d, input bit fl);
    bus_a.wr_en   = we;
    bus_a.rd_en   = re;
    bus_a.wr_data = d;
    bus_a.flush   = fl;
    @(posedge clk); #1;
    bus_a.wr_en = 1'b0;
    bus_a.rd_en = 1'b0;
    bus_a.flush = 1'b0;
  endtask

  task automatic cyc_b(input bit we, input bit re, input logic [7:0] d);
    bus_b.wr_en   = we;
    bus_b.rd_en   = re;
    bus_b.wr_data = d;
    @(posedge clk); #1;
    bus_b.wr_en = 1'b0;
    bus_b.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (bus_a.empty !== 1'b1) $display("FAIL reset_empty got %0b exp 1", bus_a.empty); else n_pass++;
    n_total++; if (bus_a.full !== 1'b0) $display("FAIL reset_full got %0b exp 0", bus_a.full); else n_pass++;
    n_total++; if (bus_a.level !== 8'd0) $display("FAIL reset_level got %0d exp 0", bus_a.level); else n_pass++;
    n_total++; if (bus_a.overrun !== 1'b0) $display("FAIL reset_overrun got %0b exp 0", bus_a.overrun); else n_pass++;
    n_total++; if (bus_a.underrun !== 1'b0) $display("FAIL reset_underrun got %0b exp 0", bus_a.underrun); else n_pass++;
    n_total++; if (bus_b.empty !== 1'b1) $display("FAIL reset_b_empty got %0b exp 1", bus_b.empty); else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    cyc(1, 0, 8'h11, 0);
    n_total++; if (bus_a.level !== 8'd1) $display("FAIL basic_level1 got %0d exp 1", bus_a.level); else n_pass++;
    n_total++; if (bus_a.rd_data !== 8'h11) $display("FAIL basic_fwft got %0h exp 11", bus_a.rd_data); else n_pass++;
    n_total++; if (bus_a.empty !== 1'b0) $display("FAIL basic_not_empty got %0b exp 0", bus_a.empty); else n_pass++;
    cyc(1, 0, 8'h22, 0);
    n_total++; if (bus_a.level !== 8'd2) $display("FAIL basic_level2 got %0d exp 2", bus_a.level); else n_pass++;
    cyc(1, 0, 8'h33, 0);
    n_total++; if (bus_a.level !== 8'd3) $display("FAIL basic_level3 got %0d exp 3", bus_a.level); else n_pass++;
    n_total++; if (bus_a.rd_data !== 8'h11) $display("FAIL basic_head got %0h exp 11", bus_a.rd_data); else n_pass++;
    cyc(0, 1, 8'h00, 0);
    n_total++; if (bus_a.rd_data !== 8'h22) $display("FAIL basic_pop1 got %0h exp 22", bus_a.rd_data); else n_pass++;
    cyc(0, 1, 8'h00, 0);
    n_total++; if (bus_a.rd_data !== 8'h33) $display("FAIL basic_pop2 got %0h exp 33", bus_a.rd_data); else n_pass++;
    cyc(0, 1, 8'h00, 0);
    n_total++; if (bus_a.empty !== 1'b1) $display("FAIL basic_empty got %0b exp 1", bus_a.empty); else n_pass++;
    n_total++; if (bus_a.level !== 8'd0) $display("FAIL basic_level0 got %0d exp 0", bus_a.level); else n_pass++;
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i), 0);
    n_total++; if (bus_a.full !== 1'b1) $display("FAIL ovr_full got %0b exp 1", bus_a.full); else n_pass++;
    n_total++; if (bus_a.level !== 8'd16) $display("FAIL ovr_level16 got %0d exp 16", bus_a.level); else n_pass++;
    n_total++; if (bus_a.overrun !== 1'b0) $display("FAIL ovr_pre got %0b exp 0", bus_a.overrun); else n_pass++;
    cyc(1, 0, 8'hAA, 0);
    n_total++; if (bus_a.overrun !== 1'b1) $display("FAIL ovr_set got %0b exp 1", bus_a.overrun); else n_pass++;
    n_total++; if (bus_a.level !== 8'd16) $display("FAIL ovr_level_hold got %0d exp 16", bus_a.level); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++; if (bus_a.rd_data !== 8'(i)) $display("FAIL ovr_order[%0d] got %0h exp %0h", i, bus_a.rd_data, 8'(i)); else n_pass++;
      cyc(0, 1, 8'h00, 0);
    end
    n_total++; if (bus_a.empty !== 1'b1) $display("FAIL ovr_drained got %0b exp 1", bus_a.empty); else n_pass++;
    n_total++; if (bus_a.overrun !== 1'b1) $display("FAIL ovr_sticky got %0b exp 1", bus_a.overrun); else n_pass++;
  endtask

  task automatic test_full_simul();
    logic [7:0] q[$];
    bit         we;
    bit         re;
    bit         push_m;
    bit         pop_m;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'h80 + 8'(i), 0);
    cyc(1, 1, 8'h5A, 0);
    n_total++; if (bus_a.level !== 8'd16) $display("FAIL fullrw_level got %0d exp 16", bus_a.level); else n_pass++;
    n_total++; if (bus_a.overrun !== 1'b0) $display("FAIL fullrw_overrun got %0b exp 0", bus_a.overrun); else n_pass++;
    for (int i = 1; i < 16; i++) begin
      n_total++; if (bus_a.rd_data !== 8'h80 + 8'(i)) $display("FAIL fullrw_old[%0d] got %0h exp %0h", i, bus_a.rd_data, 8'h80 + 8'(i)); else n_pass++;
      cyc(0, 1, 8'h00, 0);
    end
    n_total++; if (bus_a.rd_data !== 8'h5A) $display("FAIL fullrw_new got %0h exp 5a", bus_a.rd_data); else n_pass++;
    q.push_back(8'h5A);
    // Mixed traffic across pointer wrap against a reference queue.
    for (int i = 0; i < 40; i++) begin
      we = (i % 3) != 2;
      re = (i % 5) >= 2;
      d  = 8'(i * 7 + 3);
      push_m = we && ((q.size() < 16) || re);
      pop_m  = re && (q.size() > 0);
      if (q.size() > 0) begin
        n_total++; if (bus_a.rd_data !== q[0]) $display("FAIL mixed_data[%0d] got %0h exp %0h", i, bus_a.rd_data, q[0]); else n_pass++;
      end
      cyc(we, re, d, 0);
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(d);
      n_total++; if (bus_a.level !== 8'(q.size())) $display("FAIL mixed_level[%0d] got %0d exp %0d", i, bus_a.level, q.size()); else n_pass++;
    end
  endtask

  task automatic test_empty_simul();
    do_reset();
    cyc(1, 1, 8'h77, 0);
    n_total++; if (bus_a.underrun !== 1'b1) $display("FAIL emprw_underrun got %0b exp 1", bus_a.underrun); else n_pass++;
    n_total++; if (bus_a.level !== 8'd1) $display("FAIL emprw_level got %0d exp 1", bus_a.level); else n_pass++;
    n_total++; if (bus_a.rd_data !== 8'h77) $display("FAIL emprw_data got %0h exp 77", bus_a.rd_data); else n_pass++;
    cyc(0, 0, 8'h00, 0);
    n_total++; if (bus_a.underrun !== 1'b0) $display("FAIL emprw_pulse_end got %0b exp 0", bus_a.underrun); else n_pass++;
    cyc(0, 1, 8'h00, 0);
    n_total++; if (bus_a.empty !== 1'b1) $display("FAIL emprw_popped got %0b exp 1", bus_a.empty); else n_pass++;
    cyc(0, 1, 8'h00, 0);
    n_total++; if (bus_a.underrun !== 1'b1) $display("FAIL undr_pulse got %0b exp 1", bus_a.underrun); else n_pass++;
    n_total++; if (bus_a.level !== 8'd0) $display("FAIL undr_level got %0d exp 0", bus_a.level); else n_pass++;
    cyc(0, 0, 8'h00, 0);
    n_total++; if (bus_a.underrun !== 1'b0) $display("FAIL undr_end got %0b exp 0", bus_a.underrun); else n_pass++;
    cyc(1, 0, 8'h3C, 0);
    n_total++; if (bus_a.rd_data !== 8'h3C) $display("FAIL undr_ptrs got %0h exp 3c", bus_a.rd_data); else n_pass++;
    n_total++; if (bus_a.level !== 8'd1) $display("FAIL undr_ptrs_level got %0d exp 1", bus_a.level); else n_pass++;
  endtask

  task automatic test_threshold();
    do_reset();
    bus_a.threshold = 8'd4;
    #1;
    for (int i = 1; i <= 3; i++) begin
      cyc(1, 0, 8'(i), 0);
      n_total++; if (bus_a.threshold_reached !== 1'b0) $display("FAIL ge_below[%0d] got %0b exp 0", i, bus_a.threshold_reached); else n_pass++;
    end
    cyc(1, 0, 8'h04, 0);
    n_total++; if (bus_a.threshold_reached !== 1'b1) $display("FAIL ge_at4 got %0b exp 1", bus_a.threshold_reached); else n_pass++;
    cyc(0, 1, 8'h00, 0);
    n_total++; if (bus_a.threshold_reached !== 1'b0) $display("FAIL ge_fall3 got %0b exp 0", bus_a.threshold_reached); else n_pass++;
    do_reset();
    bus_a.threshold = 8'd0;
    #1;
    n_total++; if (bus_a.threshold_reached !== 1'b1) $display("FAIL ge_zero got %0b exp 1", bus_a.threshold_reached); else n_pass++;
    bus_b.threshold = 8'd1;
    #1;
    n_total++; if (bus_b.threshold_reached !== 1'b1) $display("FAIL le_lvl0 got %0b exp 1", bus_b.threshold_reached); else n_pass++;
    cyc_b(1, 0, 8'hB1);
    n_total++; if (bus_b.threshold_reached !== 1'b1) $display("FAIL le_lvl1 got %0b exp 1", bus_b.threshold_reached); else n_pass++;
    cyc_b(1, 0, 8'hB2);
    n_total++; if (bus_b.threshold_reached !== 1'b0) $display("FAIL le_lvl2 got %0b exp 0", bus_b.threshold_reached); else n_pass++;
    bus_b.threshold = 8'd200;
    #1;
    n_total++; if (bus_b.threshold_reached !== 1'b1) $display("FAIL le_big got %0b exp 1", bus_b.threshold_reached); else n_pass++;
    bus_a.threshold = 8'd4;
    bus_b.threshold = 8'd1;
  endtask

  // Fill, overrun, drain to 5 entries; then clear with flush (use_rst=0) or rst (use_rst=1).
  task automatic test_clear(input bit use_rst);
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'h40 + 8'(i), 0);
    cyc(1, 0, 8'hEE, 0);
    for (int i = 0; i < 11; i++) cyc(0, 1, 8'h00, 0);
    n_total++; if (bus_a.level !== 8'd5) $display("FAIL clr%0d_pre_level got %0d exp 5", use_rst, bus_a.level); else n_pass++;
    n_total++; if (bus_a.overrun !== 1'b1) $display("FAIL clr%0d_pre_ovr got %0b exp 1", use_rst, bus_a.overrun); else n_pass++;
    if (use_rst) begin
      rst = 1'b1;
      cyc(1, 0, 8'hCC, 0);
      rst = 1'b0;
    end else begin
      cyc(1, 0, 8'hCC, 1);
    end
    n_total++; if (bus_a.empty !== 1'b1) $display("FAIL clr%0d_empty got %0b exp 1", use_rst, bus_a.empty); else n_pass++;
    n_total++; if (bus_a.level !== 8'd0) $display("FAIL clr%0d_level got %0d exp 0", use_rst, bus_a.level); else n_pass++;
    n_total++; if (bus_a.overrun !== 1'b0) $display("FAIL clr%0d_ovr got %0b exp 0", use_rst, bus_a.overrun); else n_pass++;
    cyc(1, 0, 8'h01, 0);
    n_total++; if (bus_a.rd_data !== 8'h01) $display("FAIL clr%0d_no_cc got %0h exp 01", use_rst, bus_a.rd_data); else n_pass++;
    n_total++; if (bus_a.level !== 8'd1) $display("FAIL clr%0d_after_level got %0d exp 1", use_rst, bus_a.level); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    bus_a.flush = 1'b0; bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0; bus_a.wr_data = 8'h00; bus_a.threshold = 8'd4;
    bus_b.flush = 1'b0; bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0; bus_b.wr_data = 8'h00; bus_b.threshold = 8'd1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_overrun();
    test_full_simul();
    test_empty_simul();
    test_threshold();
    test_clear(1'b0);
    test_clear(1'b1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
